// File: rtl/axis_deadlock_scheduler.sv
// Deadlock scheduler for the AXIS channels of an HLS dataflow block: stall timeout, confirmation
// window, ordered blocked-channel report and sticky deadlock flag. Define DEADLOCK_CYCLE_STAMP_EN for the stamp port.
module axis_deadlock_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int NUM_INST    = 3,
    parameter int TIMEOUT     = 1024,
    parameter int CONFIRM_CYC = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         axis_block_sigs,
    input  logic [NUM_INST-1:0]       inst_idle_sigs,
    input  logic                      ack,
    output logic                      report_valid,
    input  logic                      report_ready,
    output logic [$clog2(NUM_CH)-1:0] report_ch,
    output logic [NUM_CH-1:0]         block_snapshot,
    output logic                      deadlock,
`ifdef DEADLOCK_CYCLE_STAMP_EN
    output logic [31:0]               stamp,
`endif
    output logic [2:0]                state_o
);

    localparam int IW = $clog2(NUM_CH);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int CW = (CONFIRM_CYC > 1) ? $clog2(CONFIRM_CYC + 1) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CONF_LAST  = CW'(CONFIRM_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MONITOR = 3'd1,
        S_CONFIRM = 3'd2,
        S_REPORT  = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t            state;
    logic [SW-1:0]     stall_cnt;
    logic [CW-1:0]     conf_cnt;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] pend_next;
    logic              all_idle;
    logic              stall;
    logic              abort;

    function automatic logic [IW-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    assign all_idle  = &inst_idle_sigs;
    assign stall     = (|axis_block_sigs) & ~all_idle;
    // Only channels that were blocked at snapshot time keep the confirmation alive.
    assign abort     = ((axis_block_sigs & block_snapshot) == '0) | all_idle;
    assign pend_next = pending & ~(NUM_CH'(1) << report_ch);
    assign state_o   = state;

`ifdef DEADLOCK_CYCLE_STAMP_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cyc_cnt <= '0;
        else        cyc_cnt <= cyc_cnt + 32'd1;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            stall_cnt      <= '0;
            conf_cnt       <= '0;
            pending        <= '0;
            block_snapshot <= '0;
            deadlock       <= 1'b0;
            report_valid   <= 1'b0;
            report_ch      <= '0;
`ifdef DEADLOCK_CYCLE_STAMP_EN
            stamp          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    stall_cnt <= '0;
                    conf_cnt  <= '0;
                    if (enable) state <= S_MONITOR;
                end
                S_MONITOR: begin
                    if (!enable) begin
                        state     <= S_IDLE;
                        stall_cnt <= '0;
                        conf_cnt  <= '0;
                    end else if (!stall) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_LAST) begin
                        block_snapshot <= axis_block_sigs;
                        conf_cnt       <= '0;
                        stall_cnt      <= '0;
                        state          <= S_CONFIRM;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                S_CONFIRM: begin
                    if (!enable) begin
                        state     <= S_IDLE;
                        stall_cnt <= '0;
                        conf_cnt  <= '0;
                    end else if (abort) begin
                        stall_cnt <= '0;
                        conf_cnt  <= '0;
                        state     <= S_MONITOR;
                    end else if (conf_cnt == CONF_LAST) begin
                        state        <= S_REPORT;
                        deadlock     <= 1'b1;
                        pending      <= block_snapshot;
                        report_valid <= 1'b1;
                        report_ch    <= lowest_idx(block_snapshot);
`ifdef DEADLOCK_CYCLE_STAMP_EN
                        stamp        <= cyc_cnt;
`endif
                    end else begin
                        conf_cnt <= conf_cnt + 1'b1;
                    end
                end
                S_REPORT, S_HALT: begin
                    // ack outranks a handshake in the same cycle
                    if (ack) begin
                        state          <= S_IDLE;
                        deadlock       <= 1'b0;
                        block_snapshot <= '0;
                        pending        <= '0;
                        report_valid   <= 1'b0;
                        report_ch      <= '0;
`ifdef DEADLOCK_CYCLE_STAMP_EN
                        stamp          <= '0;
`endif
                    end else if (state == S_REPORT && report_valid && report_ready) begin
                        pending <= pend_next;
                        if (pend_next == '0) begin
                            report_valid <= 1'b0;
                            state        <= S_HALT;
                        end else begin
                            report_ch <= lowest_idx(pend_next);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_deadlock_scheduler.sv
// Directed bench for axis_deadlock_scheduler: queue-based reference model checked every cycle,
// plus literal timing and value expectations for each scenario.
module tb_axis_deadlock_scheduler;

    localparam int NUM_CH      = 4;
    localparam int NUM_INST    = 3;
    localparam int TIMEOUT     = 8;
    localparam int CONFIRM_CYC = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic                ack = 1'b0;
    logic                report_ready = 1'b0;
    logic [NUM_CH-1:0]   axis_block_sigs = '0;
    logic [NUM_INST-1:0] inst_idle_sigs = '0;
    logic                report_valid;
    logic [1:0]          report_ch;
    logic [NUM_CH-1:0]   block_snapshot;
    logic                deadlock;
    logic [2:0]          state_o;
`ifdef DEADLOCK_CYCLE_STAMP_EN
    logic [31:0]         stamp;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    axis_deadlock_scheduler #(
        .NUM_CH(NUM_CH), .NUM_INST(NUM_INST), .TIMEOUT(TIMEOUT), .CONFIRM_CYC(CONFIRM_CYC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs),
        .ack(ack),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_ch(report_ch),
        .block_snapshot(block_snapshot),
        .deadlock(deadlock),
`ifdef DEADLOCK_CYCLE_STAMP_EN
        .stamp(stamp),
`endif
        .state_o(state_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: mode number, run lengths and a queue of channel indices still to report.
    int          m_state = 0;
    int          run = 0;
    int          conf = 0;
    int          m_cyc = 0;
    logic [3:0]  snap = '0;
    int          q[$];
    bit          dl = 1'b0;
    logic [31:0] m_stamp = '0;
    bit          exp_valid;

    task automatic model_ack();
        m_state = 0;
        snap    = '0;
        q.delete();
        dl      = 1'b0;
        m_stamp = '0;
    endtask

    task automatic model_step();
        logic st;
        logic aidle;
        aidle = &inst_idle_sigs;
        st    = (|axis_block_sigs) && !aidle;
        case (m_state)
            0: begin
                run  = 0;
                conf = 0;
                if (enable) m_state = 1;
            end
            1: begin
                if (!enable) begin
                    m_state = 0;
                    run     = 0;
                end else if (!st) begin
                    run = 0;
                end else begin
                    run++;
                    if (run == TIMEOUT) begin
                        snap    = axis_block_sigs;
                        conf    = 0;
                        m_state = 2;
                    end
                end
            end
            2: begin
                if (!enable) begin
                    m_state = 0;
                    run     = 0;
                    conf    = 0;
                end else if (((axis_block_sigs & snap) == 4'b0000) || aidle) begin
                    run     = 0;
                    m_state = 1;
                end else begin
                    conf++;
                    if (conf == CONFIRM_CYC) begin
                        m_state = 3;
                        dl      = 1'b1;
                        m_stamp = m_cyc;
                        q.delete();
                        for (int i = 0; i < NUM_CH; i++) if (snap[i]) q.push_back(i);
                    end
                end
            end
            3: begin
                if (ack) model_ack();
                else if (report_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_state = 4;
                end
            end
            4: if (ack) model_ack();
            default: ;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_ack();
                run   = 0;
                conf  = 0;
                m_cyc = 0;
            end else begin
                model_step();
                m_cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (chk_on) begin
                exp_valid = (m_state == 3) && (q.size() > 0);
                chk("state_o", 32'(state_o), m_state);
                chk("report_valid", 32'(report_valid), 32'(exp_valid));
                if (exp_valid) chk("report_ch", 32'(report_ch), q[0]);
                chk("block_snapshot", 32'(block_snapshot), 32'(snap));
                chk("deadlock", 32'(deadlock), 32'(dl));
`ifdef DEADLOCK_CYCLE_STAMP_EN
                chk("stamp", stamp, m_stamp);
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Counts falling edges until state_o reaches tgt (bounded) and checks the count.
    task automatic wait_state(input string nm, input int tgt, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (int'(state_o) != tgt && n < 100);
        chk(nm, n, exp_n);
    endtask

    initial begin
        tick(2);
        chk_on = 1'b1;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_valid", 32'(report_valid), 0);
        chk("rst_deadlock", 32'(deadlock), 0);
        chk("rst_snapshot", 32'(block_snapshot), 0);
        reset = 1'b1;

        // Scenario 1: sustained stall on channels 0 and 2, continuous ready.
        report_ready = 1'b1;
        enable       = 1'b1;
        wait_state("t1_to_monitor", 1, 1);
        axis_block_sigs = 'b0101;
        wait_state("t1_confirm_after_timeout", 2, 8);
        chk("t1_snapshot", 32'(block_snapshot), 'b0101);
        wait_state("t1_report_after_confirm", 3, 4);
        chk("t1_deadlock", 32'(deadlock), 1);
        chk("t1_first_ch", 32'(report_ch), 0);
        tick(1);
        chk("t1_second_valid", 32'(report_valid), 1);
        chk("t1_second_ch", 32'(report_ch), 2);
        tick(1);
        chk("t1_halt", 32'(state_o), 4);
        chk("t1_halt_valid", 32'(report_valid), 0);
        axis_block_sigs = '0;
        tick(3);
        chk("t1_halt_hold", 32'(state_o), 4);
        chk("t1_halt_deadlock", 32'(deadlock), 1);

        // ack in HALT together with ready
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("t5_ack_state", 32'(state_o), 0);
        chk("t5_ack_deadlock", 32'(deadlock), 0);
        chk("t5_ack_snapshot", 32'(block_snapshot), 0);

        // Scenario 2: ack ignored in MONITOR, then an interrupted stall restarts the count.
        wait_state("t2_monitor", 1, 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("t5_ack_ignored_monitor", 32'(state_o), 1);
        axis_block_sigs = 'b0101;
        tick(7);
        chk("t2_still_monitor", 32'(state_o), 1);
        axis_block_sigs = '0;
        tick(1);
        chk("t2_gap_monitor", 32'(state_o), 1);
        axis_block_sigs = 'b0101;
        report_ready    = 1'b0;
        wait_state("t2_confirm_after_restart", 2, 8);
        wait_state("t2_report", 3, 4);
        chk("t2_deadlock", 32'(deadlock), 1);
        ack = 1'b1;
        tick(1);
        ack             = 1'b0;
        axis_block_sigs = '0;
        chk("t2_ack_in_report", 32'(state_o), 0);
        chk("t2_ack_valid", 32'(report_valid), 0);

        // Scenario 3: abort from CONFIRM when the snapshotted channel unblocks.
        wait_state("t3_monitor", 1, 1);
        axis_block_sigs = 'b0010;
        wait_state("t3_confirm", 2, 8);
        chk("t3_snapshot", 32'(block_snapshot), 'b0010);
        tick(1);
        axis_block_sigs = 'b1000;
        tick(1);
        chk("t3_abort_state", 32'(state_o), 1);
        chk("t3_abort_deadlock", 32'(deadlock), 0);
        wait_state("t3_counter_restarted", 2, 8);
        enable = 1'b0;
        tick(1);
        chk("t3_disable_idle", 32'(state_o), 0);
        axis_block_sigs = '0;

        // Scenario 4: backpressure, then flags appearing after snapshot stay out of the report.
        enable          = 1'b1;
        axis_block_sigs = 'b1011;
        wait_state("t4_monitor", 1, 1);
        wait_state("t4_confirm", 2, 8);
        axis_block_sigs = 'b1111;
        wait_state("t4_report", 3, 4);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(report_valid), 1);
            chk("t4_hold_ch", 32'(report_ch), 0);
            tick(1);
        end
        chk("t4_hold_last_ch", 32'(report_ch), 0);
        report_ready = 1'b1;
        tick(1);
        chk("t4_ch1", 32'(report_ch), 1);
        tick(1);
        chk("t4_ch3", 32'(report_ch), 3);
        tick(1);
        chk("t4_done_valid", 32'(report_valid), 0);
        chk("t4_done_halt", 32'(state_o), 4);
        ack = 1'b1;
        tick(1);
        ack             = 1'b0;
        report_ready    = 1'b0;
        axis_block_sigs = 'b0101;

        // Scenario 5: asynchronous reset in the middle of REPORT.
        wait_state("t6_monitor", 1, 1);
        wait_state("t6_confirm", 2, 8);
        wait_state("t6_report", 3, 4);
        chk("t6_valid_before", 32'(report_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_valid", 32'(report_valid), 0);
        chk("t6_async_deadlock", 32'(deadlock), 0);
        chk("t6_async_state", 32'(state_o), 0);
`ifdef DEADLOCK_CYCLE_STAMP_EN
        chk("t6_async_stamp", stamp, 0);
`endif
        tick(1);
        reset = 1'b1;
        chk("t6_after_release", 32'(state_o), 0);
        tick(1);
        enable          = 1'b0;
        axis_block_sigs = '0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_deadlock_scheduler.md
Name: axis_deadlock_scheduler

Overview:
Sequences deadlock checking for the AXIS channels of an HLS-generated dataflow block (e.g. the encoder) during co-simulation and emulation. It filters the raw per-channel block flags through a stall timeout and a confirmation window, then declares a deadlock. It reports each blocked channel index over a valid/ready handshake and holds a sticky deadlock flag until software acknowledges. It sits above the per-instance deadlock monitors and feeds the testbench or host status path.

Parameters:
NUM_CH, 4, number of AXIS channels monitored (2..16)
NUM_INST, 3, number of sub-instance idle flags (1..8)
TIMEOUT, 1024, consecutive blocked cycles before confirmation starts (>=2)
CONFIRM_CYC, 16, length of the confirmation window in cycles (>=1)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous reset, active-low
enable  in  1  monitoring enable
axis_block_sigs  in  NUM_CH  per-channel block flag, bit i = channel i blocked
inst_idle_sigs  in  NUM_INST  per-instance idle flags
ack  in  1  clears the deadlock report; pulse
report_valid  out  1  blocked-channel index is valid
report_ready  in  1  consumer accepts the index
report_ch  out  clog2(NUM_CH)  blocked channel index
block_snapshot  out  NUM_CH  channel set latched at confirmation entry
deadlock  out  1  sticky deadlock flag
state_o  out  3  FSM state encoding, for debug

Behaviour:
- Reset: all outputs are 0. FSM enters IDLE. Stall counter, confirm counter and snapshot are 0. Reset takes effect immediately, including mid-report; report_valid drops asynchronously.
- any_blk = |axis_block_sigs. all_idle = &inst_idle_sigs. stall = any_blk & ~all_idle.
- FSM states: IDLE=0, MONITOR=1, CONFIRM=2, REPORT=3, HALT=4.
- IDLE: counters are held at 0. Moves to MONITOR on the next edge when enable=1.
- MONITOR: the stall counter, of width clog2(TIMEOUT+1), increments while stall=1 and clears to 0 on any cycle with stall=0. On the edge where the counter equals TIMEOUT-1 and stall=1:
  - block_snapshot <= axis_block_sigs
  - confirm counter <= 0
  - FSM moves to CONFIRM. CONFIRM is entered exactly TIMEOUT cycles after the first stall cycle.
- CONFIRM: each cycle, if (axis_block_sigs & block_snapshot) == 0 or all_idle=1, the check is aborted. Abort clears the stall counter and returns the FSM to MONITOR. Otherwise the confirm counter increments. When it reaches CONFIRM_CYC-1 without abort, the FSM moves to REPORT and deadlock <= 1 on that same edge.
- REPORT: the block emits the set bits of block_snapshot in ascending index order.
  - report_valid=1 and report_ch = lowest pending index.
  - On report_valid & report_ready the bit is retired and the next index appears the following cycle, giving 1 index per cycle under continuous ready.
  - report_ch is stable while valid=1 and ready=0.
  - After the last bit is retired, report_valid=0 and the FSM moves to HALT.
- HALT: deadlock is held at 1. Input block flags are ignored.
- ack=1 in REPORT or HALT clears deadlock, block_snapshot and pending bits, and moves the FSM to IDLE. ack has priority over a simultaneous handshake.
- enable=0 in MONITOR or CONFIRM moves the FSM to IDLE next edge and clears the counters. enable=0 in REPORT or HALT has no effect; only ack or reset leaves those states.
- ack in IDLE, MONITOR or CONFIRM is ignored.
- Blocked flags that appear after the snapshot is taken never join the report.

Optional Feature:
DEADLOCK_CYCLE_STAMP_EN
- Defined: adds a 32-bit free-running cycle counter (reset 0, wraps 0xFFFFFFFF->0) and an output port stamp[31:0]. stamp latches the counter value on the edge that sets deadlock and is cleared by ack or reset.
- Undefined: no counter and no stamp port. All other behaviour is identical.

Test Plan:
1. TIMEOUT=8, CONFIRM_CYC=4, enable=1, axis_block_sigs=4'b0101 held, inst_idle=3'b000 -> CONFIRM entered 8 cycles after first stall; deadlock=1 4 cycles later; report_ch 0 then 2 with report_ready=1; FSM then in HALT.
2. Same config, stall for 7 cycles, 1 cycle of axis_block_sigs=0, then stall again -> counter restarts; deadlock asserts 8+4 cycles after the restart, not earlier.
3. Snapshot 4'b0010; in the 2nd CONFIRM cycle axis_block_sigs=4'b1000 -> abort to MONITOR with counter 0; no report; deadlock stays 0.
4. In REPORT with snapshot 4'b1011, report_ready=0 for 5 cycles -> report_valid=1 and report_ch=0 stable; then ready=1 -> indices 0,1,3 on consecutive cycles.
5. ack pulsed in HALT together with report_ready -> deadlock=0, snapshot=0, FSM IDLE next cycle; ack pulsed in MONITOR -> ignored.
6. Reset asserted (0) mid-REPORT -> report_valid and deadlock go 0 without waiting for a clock edge; FSM is IDLE after release. With DEADLOCK_CYCLE_STAMP_EN defined, stamp = cycle index of the deadlock edge and returns to 0 on reset.
